// File: rtl/ik_iterate_pkg.sv
// ---------------------------------------------------------------------------
// ik_iterate_pkg
// Shared definitions for the iterative IK controller: word width, fixed-point
// format, the wrap constants PI / 2PI in Q.16 and the controller state codes.
// ---------------------------------------------------------------------------
package ik_iterate_pkg;

   localparam int IK_W    = 36;  // signed joint/pose word width
   localparam int IK_FRAC = 16;  // fractional bits, 65536 = 1.0

   localparam logic signed [IK_W-1:0] IK_PI     = 36'sd205887;
   localparam logic signed [IK_W-1:0] IK_TWO_PI = 36'sd411775;

   // Controller states, kept as plain 3-bit codes for compatibility with
   // existing tooling that decodes the state register directly.
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_LOAD   = 3'd1;
   localparam state_t S_KICK   = 3'd2;
   localparam state_t S_RUN    = 3'd3;
   localparam state_t S_UPDATE = 3'd4;
   localparam state_t S_CHECK  = 3'd5;
   localparam state_t S_DONE   = 3'd6;

endpackage

// File: rtl/ik_iterate_if.sv
// ---------------------------------------------------------------------------
// ik_iterate_if
// Link between the iteration controller and one solver step engine.
//   solver_rst        : one-cycle reset pulse before each iteration
//   solver_en         : enable, high only while the solver runs
//   solver_dh_dyn_in  : current joint values
//   solver_target     : goal pose captured at solve start
//   solver_done       : iteration complete
//   solver_dh_dyn_out : updated joint values
//   solver_delta      : signed per-joint step of the last iteration
// master = controller side, slave = solver side.
// ---------------------------------------------------------------------------
interface ik_iterate_if import ik_iterate_pkg::*; #(
   parameter int N_JOINTS = 6,
   parameter int W        = IK_W
);
   logic                         solver_rst;
   logic                         solver_en;
   logic [N_JOINTS-1:0][W-1:0]   solver_dh_dyn_in;
   logic [N_JOINTS-1:0][W-1:0]   solver_target;
   logic                         solver_done;
   logic [N_JOINTS-1:0][W-1:0]   solver_dh_dyn_out;
   logic [N_JOINTS-1:0][W-1:0]   solver_delta;

   modport master (
      output solver_rst, solver_en, solver_dh_dyn_in, solver_target,
      input  solver_done, solver_dh_dyn_out, solver_delta
   );

   modport slave (
      input  solver_rst, solver_en, solver_dh_dyn_in, solver_target,
      output solver_done, solver_dh_dyn_out, solver_delta
   );
endinterface

// File: rtl/ik_iterate_angle_wrap.sv
// ---------------------------------------------------------------------------
// angle_wrap
// Single-step angle wrap for one joint. Rotational joints above PI lose 2PI,
// below -PI gain 2PI; translational joints pass through untouched.
//   theta_in  : raw joint value (signed Q.16)
//   is_rot    : 1 = rotational joint
//   theta_out : wrapped joint value
// ---------------------------------------------------------------------------
module angle_wrap import ik_iterate_pkg::*; #(
   parameter int W = IK_W
) (
   input  logic [W-1:0] theta_in,
   input  logic         is_rot,
   output logic [W-1:0] theta_out
);

   localparam logic signed [W-1:0] PI_W     = W'(IK_PI);
   localparam logic signed [W-1:0] TWO_PI_W = W'(IK_TWO_PI);

   logic signed [W-1:0] theta_s;
   assign theta_s = $signed(theta_in);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch cannot be inferred.
   always_comb begin
      theta_out = theta_in;
      if (is_rot && (theta_s > PI_W)) begin
         theta_out = $unsigned(theta_s - TWO_PI_W);
      end else if (is_rot && (theta_s < -PI_W)) begin
         theta_out = $unsigned(theta_s + TWO_PI_W);
      end
   end

endmodule

// File: rtl/ik_iterate.sv
// ---------------------------------------------------------------------------
// ik_iterate
// Iteration controller for a numeric IK solver. Captures a problem on start,
// then repeatedly resets/runs the solver, folds its joint update back in
// (with angle wrap) and stops on convergence (max |delta| < tol) or when
// max_iter iterations are done.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle solve request (honoured in IDLE/DONE only)
//   theta_init    : initial joint values      target : goal pose
//   joint_type    : 1 = rotational per joint  max_iter, tol : stop criteria
//   busy          : solve in progress         result_valid : result ready
//   converged     : stopped on tolerance      iter_count : iterations done
//   theta_out     : final joint values        solver : link to the solver
// ---------------------------------------------------------------------------
module ik_iterate import ik_iterate_pkg::*; #(
   parameter int N_JOINTS = 6,
   parameter int W        = IK_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N_JOINTS-1:0][W-1:0] theta_init,
   input  logic [N_JOINTS-1:0][W-1:0] target,
   input  logic [N_JOINTS-1:0]        joint_type,
   input  logic [7:0]                 max_iter,
   input  logic [W-1:0]               tol,
   output logic                       busy,
   output logic                       result_valid,
   output logic                       converged,
   output logic [7:0]                 iter_count,
   output logic [N_JOINTS-1:0][W-1:0] theta_out,
   ik_iterate_if.master               solver
);

   state_t                     state;
   logic [N_JOINTS-1:0][W-1:0] theta_q;
   logic [N_JOINTS-1:0][W-1:0] target_q;
   logic [N_JOINTS-1:0]        jtype_q;
   logic [7:0]                 max_iter_q;
   logic [W-1:0]               tol_q;
   logic [W:0]                 mag_q;

   logic [N_JOINTS-1:0][W-1:0] theta_wrapped;
   logic [W:0]                 mag_next;
   logic signed [W:0]          delta_ext;
   logic [W:0]                 delta_abs;

   for (genvar j = 0; j < N_JOINTS; j++) begin : g_wrap
      angle_wrap #(.W(W)) u_wrap (
         .theta_in  (solver.solver_dh_dyn_out[j]),
         .is_rot    (jtype_q[j]),
         .theta_out (theta_wrapped[j])
      );
   end

   // Largest step magnitude. One extra bit keeps |-2^(W-1)| representable.
   always_comb begin
      mag_next  = '0;
      delta_ext = '0;
      delta_abs = '0;
      for (int j = 0; j < N_JOINTS; j++) begin
         delta_ext = $signed({solver.solver_delta[j][W-1], solver.solver_delta[j]});
         delta_abs = delta_ext[W] ? $unsigned(-delta_ext) : $unsigned(delta_ext);
         if (delta_abs > mag_next) mag_next = delta_abs;
      end
   end

   // Solver inputs only change in LOAD/UPDATE, so they are stable from KICK
   // through the end of RUN.
   assign solver.solver_rst       = (state == S_KICK);
   assign solver.solver_en        = (state == S_RUN);
   assign solver.solver_dh_dyn_in = theta_q;
   assign solver.solver_target    = target_q;

   assign busy = (state == S_LOAD) || (state == S_KICK) || (state == S_RUN) ||
                 (state == S_UPDATE) || (state == S_CHECK);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the joint registers are reset too: they drive solver_dh_dyn_in
   // and theta_out, which must read zero while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         theta_q      <= '0;
         target_q     <= '0;
         jtype_q      <= '0;
         max_iter_q   <= '0;
         tol_q        <= '0;
         mag_q        <= '0;
         iter_count   <= '0;
         converged    <= 1'b0;
         result_valid <= 1'b0;
         theta_out    <= '0;
      end else begin
         case (state)
            // The problem is captured with the accepted start, so the LOAD
            // cycle already holds it and only has to pick the next state.
            S_IDLE, S_DONE: begin
               if (start) begin
                  theta_q      <= theta_init;
                  target_q     <= target;
                  jtype_q      <= joint_type;
                  max_iter_q   <= max_iter;
                  tol_q        <= tol;
                  iter_count   <= '0;
                  converged    <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (max_iter_q == 8'd0) begin
                  result_valid <= 1'b1;
                  theta_out    <= theta_q;
                  state        <= S_DONE;
               end else begin
                  state <= S_KICK;
               end
            end
            S_KICK: state <= S_RUN;
            S_RUN: begin
               if (solver.solver_done) state <= S_UPDATE;
            end
            S_UPDATE: begin
               theta_q    <= theta_wrapped;
               iter_count <= iter_count + 8'd1;
               mag_q      <= mag_next;
               state      <= S_CHECK;
            end
            S_CHECK: begin
               if (mag_q < {1'b0, tol_q}) begin
                  converged    <= 1'b1;
                  result_valid <= 1'b1;
                  theta_out    <= theta_q;
                  state        <= S_DONE;
               end else if (iter_count == max_iter_q) begin
                  result_valid <= 1'b1;
                  theta_out    <= theta_q;
                  state        <= S_DONE;
               end else begin
                  state <= S_KICK;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ik_iterate.sv
// ---------------------------------------------------------------------------
// tb_ik_iterate
// Drives ik_iterate against a stub solver (done 250 cycles after enable
// rises, programmable delta / dh_dyn_out) and compares every result with a
// loop-level reference model of the iteration rules.
// ---------------------------------------------------------------------------
module tb_ik_iterate;
   import ik_iterate_pkg::*;

   localparam int     N        = 6;
   localparam int     W        = IK_W;
   localparam int     STUB_LAT = 250;
   localparam longint ONE      = longint'(1) << IK_FRAC;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [N-1:0][W-1:0] theta_init = '0;
   logic [N-1:0][W-1:0] target = '0;
   logic [N-1:0]        joint_type = '0;
   logic [7:0]          max_iter = '0;
   logic [W-1:0]        tol = '0;
   logic                busy, result_valid, converged;
   logic [7:0]          iter_count;
   logic [N-1:0][W-1:0] theta_out;

   ik_iterate_if #(.N_JOINTS(N), .W(W)) sif ();

   ik_iterate #(.N_JOINTS(N), .W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .theta_init   (theta_init),
      .target       (target),
      .joint_type   (joint_type),
      .max_iter     (max_iter),
      .tol          (tol),
      .busy         (busy),
      .result_valid (result_valid),
      .converged    (converged),
      .iter_count   (iter_count),
      .theta_out    (theta_out),
      .solver       (sif)
   );

   always #5 clk = ~clk;

   // ---------------- problem description / reference model ----------------
   longint       m_init [N];
   longint       m_dh   [N];
   longint       m_delta[N];
   logic [N-1:0] m_jt = '0;
   int           m_max_iter = 0;
   longint       m_tol = 0;
   longint       exp_theta[N];
   int           exp_iter = 0;
   bit           exp_conv = 1'b0;

   function automatic logic [W-1:0] to_w(input longint v);
      return v[W-1:0];
   endfunction

   function automatic longint rnd_w();
      longint t;
      t = longint'({$urandom, $urandom} << (64 - W));
      return t >>> (64 - W);
   endfunction

   function automatic longint wrap_ref(input longint v, input bit rot);
      if (rot && v > 205887)  return v - 411775;
      if (rot && v < -205887) return v + 411775;
      return v;
   endfunction

   task automatic model_solve();
      longint m, a;
      for (int j = 0; j < N; j++) exp_theta[j] = m_init[j];
      exp_iter = 0;
      exp_conv = 1'b0;
      for (int it = 1; it <= m_max_iter; it++) begin
         m = 0;
         for (int j = 0; j < N; j++) begin
            exp_theta[j] = wrap_ref(m_dh[j], m_jt[j]);
            a = (m_delta[j] < 0) ? -m_delta[j] : m_delta[j];
            if (a > m) m = a;
         end
         exp_iter = it;
         if (m < m_tol) begin
            exp_conv = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- stub solver ----------------
   logic stub_done, en_d;
   logic force_done = 1'b0;
   int   stub_cnt;

   for (genvar i = 0; i < N; i++) begin : g_stub
      assign sif.solver_dh_dyn_out[i] = m_dh[i][W-1:0];
      assign sif.solver_delta[i]      = m_delta[i][W-1:0];
   end
   assign sif.solver_done = stub_done | force_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_cnt  <= 0;
         stub_done <= 1'b0;
         en_d      <= 1'b0;
      end else begin
         en_d      <= sif.solver_en;
         stub_done <= 1'b0;
         if (sif.solver_rst)                    stub_cnt <= 0;
         else if (sif.solver_en && !en_d)       stub_cnt <= 1;
         else if (stub_cnt == STUB_LAT - 1) begin
            stub_cnt  <= 0;
            stub_done <= 1'b1;
         end else if (stub_cnt != 0)            stub_cnt <= stub_cnt + 1;
      end
   end

   // ---------------- event monitor (sampled on the falling edge) ----------------
   int   cyc = 0, done_cyc = 0, rv_cyc = 0, kicks = 0;
   logic rv_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (sif.solver_done)          done_cyc = cyc;
      if (result_valid && !rv_prev) rv_cyc = cyc;
      rv_prev = result_valid;
      if (sif.solver_rst)           kicks++;
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/busy"},         64'(busy), 64'(1'b0));
      check({tag, "/result_valid"}, 64'(result_valid), 64'(1'b0));
      check({tag, "/converged"},    64'(converged), 64'(1'b0));
      check({tag, "/iter_count"},   64'(iter_count), 64'(8'd0));
      check({tag, "/theta_out_nz"}, 64'(theta_out != '0), 64'(1'b0));
      check({tag, "/solver_rst"},   64'(sif.solver_rst), 64'(1'b0));
      check({tag, "/solver_en"},    64'(sif.solver_en), 64'(1'b0));
      check({tag, "/dh_in_nz"},     64'(sif.solver_dh_dyn_in != '0), 64'(1'b0));
   endtask

   task automatic drive_inputs();
      for (int j = 0; j < N; j++) begin
         theta_init[j] = to_w(m_init[j]);
         target[j]     = to_w(rnd_w());
      end
      joint_type = m_jt;
      max_iter   = 8'(m_max_iter);
      tol        = to_w(m_tol);
   endtask

   task automatic random_problem();
      for (int j = 0; j < N; j++) begin
         m_init[j]  = rnd_w();
         m_dh[j]    = longint'($urandom_range(0, 1200000)) - 600000;
         m_delta[j] = longint'($urandom_range(0, 2097152)) - 1048576;
      end
      m_jt = N'($urandom);
   endtask

   // Full solve: start, wait (bounded) for result_valid, compare with model.
   task automatic do_solve(input string tag, input bit poke);
      int n, base_k, budget;
      model_solve();
      drive_inputs();
      budget = 300 * (m_max_iter + 1) + 20;
      @(negedge clk);
      start = 1'b1;
      #1 base_k = kicks;
      @(negedge clk);
      start = 1'b0;
      check({tag, "/busy_load"}, 64'(busy), 64'(1'b1));
      check({tag, "/rv_cleared"}, 64'(result_valid), 64'(1'b0));
      n = 1;
      while (!result_valid && n < budget) begin
         @(negedge clk);
         n++;
         if (poke && n == 100) begin
            start      = 1'b1;
            theta_init = '1;
            max_iter   = 8'd0;
            @(negedge clk);
            n++;
            start = 1'b0;
            check({tag, "/poke_busy"}, 64'(busy), 64'(1'b1));
            check({tag, "/poke_iter"}, 64'(iter_count), 64'(8'd0));
         end
      end
      #1;
      check({tag, "/result_valid"}, 64'(result_valid), 64'(1'b1));
      check({tag, "/busy_done"},    64'(busy), 64'(1'b0));
      check({tag, "/converged"},    64'(converged), 64'(exp_conv));
      check({tag, "/iter_count"},   64'(iter_count), 64'(exp_iter));
      check({tag, "/kicks"},        64'(kicks - base_k), 64'(exp_iter));
      check({tag, "/target_pass"},  64'(sif.solver_target != target), 64'(1'b0));
      for (int j = 0; j < N; j++)
         check($sformatf("%s/theta%0d", tag, j), 64'(theta_out[j]), 64'(to_w(exp_theta[j])));
      if (exp_iter > 0) check({tag, "/latency"}, 64'(rv_cyc - done_cyc), 64'(3));
      else              check({tag, "/fast_done"}, 64'(n <= 2), 64'(1'b1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, base_k;

      // Reset state.
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // solver_done while IDLE is ignored.
      @(negedge clk);
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      @(negedge clk);
      check("idle_done/busy", 64'(busy), 64'(1'b0));
      check("idle_done/en",   64'(sif.solver_en), 64'(1'b0));
      check("idle_done/rv",   64'(result_valid), 64'(1'b0));

      // max_iter = 0 goes straight to DONE with theta_init.
      random_problem();
      m_max_iter = 0;
      m_tol      = ONE;
      do_solve("max_iter0", 1'b0);
      check("max_iter0/theta0_init", 64'(theta_out[0]), 64'(to_w(m_init[0])));

      // Converges on the first iteration.
      random_problem();
      for (int j = 0; j < N; j++) m_delta[j] = 6553;
      m_max_iter = 4;
      m_tol      = ONE;
      do_solve("conv1", 1'b0);
      check("conv1/converged_const", 64'(converged), 64'(1'b1));
      check("conv1/iter_const",      64'(iter_count), 64'(8'd1));

      // solver_done while DONE is ignored.
      @(negedge clk);
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      @(negedge clk);
      check("done_done/rv",   64'(result_valid), 64'(1'b1));
      check("done_done/iter", 64'(iter_count), 64'(8'd1));
      check("done_done/busy", 64'(busy), 64'(1'b0));

      // Never converges, runs out at max_iter; a start while busy is ignored.
      random_problem();
      for (int j = 0; j < N; j++) m_delta[j] = (j == 2) ? -ONE : ONE;
      m_max_iter = 5;
      m_tol      = 1;
      do_solve("noconv5", 1'b1);
      check("noconv5/iter_const", 64'(iter_count), 64'(8'd5));

      // Wrap: rotational vs translational joints at the PI boundary.
      random_problem();
      m_jt = 6'b010101;
      for (int j = 0; j < N; j++) m_dh[j] = 205888;
      m_dh[2] = -205888;
      m_dh[5] = 205887;
      m_jt[5] = 1'b1;
      m_max_iter = 1;
      m_tol      = ONE;
      do_solve("wrap", 1'b0);
      check("wrap/rot_pos",   64'(theta_out[0]), 64'(to_w(-205887)));
      check("wrap/trans",     64'(theta_out[1]), 64'(to_w(205888)));
      check("wrap/rot_neg",   64'(theta_out[2]), 64'(to_w(205887)));
      check("wrap/rot_at_pi", 64'(theta_out[5]), 64'(to_w(205887)));

      // Most negative delta: |-2^35| must compare as 2^35.
      random_problem();
      for (int j = 0; j < N; j++) m_delta[j] = 0;
      m_delta[3] = -(longint'(1) << 35);
      m_max_iter = 2;
      m_tol      = (longint'(1) << 35) + 1;
      do_solve("minneg_conv", 1'b0);
      m_tol      = longint'(1) << 35;
      do_solve("minneg_noconv", 1'b0);

      // Reset during the RUN of iteration 2 aborts with no result.
      random_problem();
      for (int j = 0; j < N; j++) m_delta[j] = ONE;
      m_max_iter = 5;
      m_tol      = 1;
      drive_inputs();
      @(negedge clk);
      start = 1'b1;
      #1 base_k = kicks;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!((kicks - base_k) >= 2 && sif.solver_en) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("abort/reach_run2", 64'(kicks - base_k), 64'(2));
      check("abort/iter_before", 64'(iter_count), 64'(8'd1));
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("abort_async");
      @(negedge clk);
      check_all_zero("abort");
      rst = 1'b0;

      random_problem();
      m_max_iter = 2;
      m_tol      = longint'($urandom_range(0, 2097152));
      do_solve("after_abort", 1'b0);

      // Randomised problems.
      for (int r = 0; r < 4; r++) begin
         random_problem();
         m_max_iter = $urandom_range(1, 3);
         m_tol      = longint'($urandom_range(0, 2097152));
         do_solve($sformatf("rand%0d", r), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
